fir_wb_responder: RTL and testbench
===================================

Name: fir_wb_responder

Overview:
- Wishbone classic responder containing a self-contained sequential-MAC FIR engine, so any Wishbone initiator in the FIR subsystem can push samples and pop results by register access.
- Samples enter through a 4-deep input FIFO.
- One multiply-accumulate runs per clock across N taps.
- Saturated results leave through a 4-deep output FIFO.
- A level interrupt tells the initiator that results are waiting.

Parameters:
- N, 4, number of taps; legal range 1..12 (coefficients occupy addresses 4..4+N-1).
- DATA_WIDTH, 16, width of samples, coefficients and the Wishbone data bus; samples and coefficients are signed Q1.(DATA_WIDTH-1).

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- adr_i  in  4  word address.
- dat_i  in  DATA_WIDTH  write data.
- dat_o  out  DATA_WIDTH  read data, valid while ack_o=1.
- we_i  in  1  1=write, 0=read.
- stb_i  in  1  strobe.
- cyc_i  in  1  bus cycle.
- ack_o  out  1  registered single-cycle acknowledge.
- irq_o  out  1  level interrupt: CTRL.IE & CTRL.EN & output FIFO not empty.

Behaviour:
- Reset (asynchronous, active-high) values:
  - ack_o=0, dat_o=0, irq_o=0.
  - CTRL=0, all coefficients=0, delay line=0.
  - Both FIFOs empty, sticky flags=0, FSM=IDLE.
- Reset asserted mid-transfer or mid-MAC aborts immediately; no result is pushed.
- Bus handshake:
  - Request = stb_i & cyc_i & ~ack_o.
  - ack_o is asserted the cycle after a request (one wait state) and held exactly one cycle.
  - The register action (write, or FIFO pop on read) occurs on the edge that raises ack_o.
  - Back-to-back requests therefore ack at most every other cycle.
  - If stb_i or cyc_i drops before ack_o rises, nothing happens.
- Coefficient writes while the FSM is not IDLE are stalled: no ack until the FSM returns to IDLE, then normal ack. All other accesses are never stalled.
- Register map:
  - 0 CTRL (RW): bit0 EN; bit1 CLR, write-1 self-clearing, flushes both FIFOs, delay line and sticky flags, FSM forced to IDLE; bit2 IE.
  - 1 STATUS (RO, except W1C on bits 5-6):
    - bit0 BUSY (FSM not IDLE), bit1 IN_EMPTY, bit2 IN_FULL, bit3 OUT_EMPTY, bit4 OUT_FULL.
    - bit5 OVF sticky, bit6 UNF sticky.
    - bits 9:7 output FIFO count (0..4); other bits 0.
  - 2 DATA_IN (WO): pushes dat_i into the input FIFO. If full: sample dropped, OVF set, still acked. Reads return 0.
  - 3 DATA_OUT (RO): pops the output FIFO onto dat_o. If empty: dat_o=0, UNF set. Writes ignored.
  - 4..4+N-1 COEF[k] (RW); coefficient k multiplies the sample delayed by k.
  - Unmapped addresses: reads 0, writes ignored, always acked.
- FSM (one state per cycle):
  - IDLE -> SHIFT when EN=1, input FIFO non-empty and output FIFO not full; otherwise stay in IDLE.
  - SHIFT: pop the input FIFO, shift the sample into x[0], older samples move to x[k+1], clear the accumulator.
  - MAC: N cycles, k=0..N-1, acc += x[k]*COEF[k].
  - ROUND: push the result, then go to IDLE.
  - Clearing EN while not IDLE lets the current sample finish.
- Latency: with the FSM idle, a DATA_IN write acked at edge t produces a result in the output FIFO at edge t+N+3; OUT_EMPTY clears and irq_o rises in that same cycle.
- Arithmetic:
  - Products are signed 2*DATA_WIDTH bits.
  - The accumulator is 2*DATA_WIDTH+4 bits and never wraps for N≤12.
  - Result = acc arithmetic-shifted right by DATA_WIDTH-1 (truncation toward -inf), saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Simultaneous events:
  - Output FIFO: a bus pop and an FSM push in the same edge are both honoured; count is unchanged.
  - Input FIFO: a bus push and an FSM pop in the same edge are both honoured; a push is accepted when the FIFO is full but popped that edge.
  - Both FIFO pointers wrap modulo 4.
- CTRL write with CLR=1 also writes EN/IE from the same data.

Test Plan:
- Reset mid-MAC: assert rst during MAC -> ack_o=0, dat_o=0, irq_o=0, STATUS=0x000A, COEF[0] reads 0.
- Impulse response, N=4, COEF={0x4000,0x2000,0x1000,0x0800}, EN=1:
  - Stimulus: write DATA_IN 0x7FFF then 0,0,0.
  - Required: DATA_OUT reads 0x3FFF, 0x1FFF, 0x0FFF, 0x07FF.
  - First result at edge t+7 after the first ack.
- Gain and saturation:
  - COEF[0]=0x4000, input 0x2000 -> output 0x1000.
  - COEF[0..3]=0x7FFF, four inputs 0x7FFF -> last output 0x7FFF (saturated).
  - Same coefficients with four inputs 0x8000 -> last output 0x8000.
- Flow control:
  - EN=0; write 5 samples -> STATUS IN_FULL=1, OVF=1.
  - Set EN=1 -> exactly 4 results.
  - A fifth DATA_OUT read -> 0 with UNF=1.
  - Write 0x60 to STATUS -> OVF and UNF read 0.
- Bus protocol:
  - ack_o high for exactly one cycle per access, never on consecutive cycles.
  - Dropping stb_i before ack_o produces no FIFO change.
  - COEF write during MAC is held off until BUSY=0, then acked.
- Interrupt and clear: IE=1, EN=1, one sample in -> irq_o=1; write CTRL=0x0007 -> irq_o=0, OUT count 0, delay line zeroed (next impulse response identical to the impulse-response scenario).

Source files
------------

// File: rtl/fir_wb_responder.sv
// fir_wb_responder: Wishbone classic responder wrapping a sequential-MAC FIR with input/output sample FIFOs.
module fir_wb_responder #(
    parameter int N = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic                  we_i,
    input  logic                  stb_i,
    input  logic                  cyc_i,
    output logic                  ack_o,
    output logic                  irq_o
);
    localparam int W = DATA_WIDTH;
    localparam int AW = 2 * W + 4;
    localparam logic [4:0] COEF_END = 5'(4 + N);
    localparam logic signed [AW-1:0] MAXV = AW'(2 ** (W - 1) - 1);
    localparam logic signed [AW-1:0] MINV = ~MAXV;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] MAC = 2'd2;
    localparam logic [1:0] ROUND = 2'd3;

    logic [1:0] state;
    logic [3:0] k;
    logic en, ie, ovf, unf;
    logic signed [W-1:0] coef [N];
    logic signed [W-1:0] x [N];
    logic signed [AW-1:0] acc;
    logic [W-1:0] in_mem [4];
    logic [W-1:0] out_mem [4];
    logic [1:0] in_rd, in_wr, out_rd, out_wr;
    logic [2:0] in_cnt, out_cnt;

    logic req, is_coef, stall, go, wr, rd, clr;
    logic in_push, in_pop, in_acc, out_push, out_pop, st_wr;
    logic [3:0] cidx;
    logic signed [W-1:0] mac_x, mac_c, coef_rd;
    logic signed [2*W-1:0] prod;
    logic signed [AW-1:0] sh;
    logic [W-1:0] result, status, rdata;

    assign req = stb_i & cyc_i & ~ack_o;
    assign is_coef = ({1'b0, adr_i} >= 5'd4) && ({1'b0, adr_i} < COEF_END);
    assign cidx = adr_i - 4'd4;
    // Coefficient writes wait for the engine so a sample never sees a mixed coefficient set
    assign stall = we_i & is_coef & (state != IDLE);
    assign go = req & ~stall;
    assign wr = go & we_i;
    assign rd = go & ~we_i;
    assign clr = wr & (adr_i == 4'd0) & dat_i[1];
    assign st_wr = wr & (adr_i == 4'd1);
    assign in_push = wr & (adr_i == 4'd2);
    assign in_pop = state == SHIFT;
    assign in_acc = in_push & ((in_cnt != 3'd4) | in_pop);
    assign out_push = state == ROUND;
    assign out_pop = rd & (adr_i == 4'd3) & (out_cnt != 3'd0);
    assign irq_o = ie & en & (out_cnt != 3'd0);
    assign prod = mac_x * mac_c;
    assign sh = acc >>> (W - 1);
    assign result = sh > MAXV ? MAXV[W-1:0] : sh < MINV ? MINV[W-1:0] : sh[W-1:0];
    assign status = W'({out_cnt, unf, ovf, out_cnt == 3'd4, out_cnt == 3'd0,
                        in_cnt == 3'd4, in_cnt == 3'd0, state != IDLE});

    always_comb begin
        mac_x = '0;
        mac_c = '0;
        coef_rd = '0;
        for (int i = 0; i < N; i++) begin
            if (k == 4'(i)) begin
                mac_x = x[i];
                mac_c = coef[i];
            end
            if (cidx == 4'(i)) coef_rd = coef[i];
        end
    end

    always_comb begin
        rdata = '0;
        if (adr_i == 4'd0) rdata = W'({ie, 1'b0, en});
        else if (adr_i == 4'd1) rdata = status;
        else if (adr_i == 4'd3) rdata = out_cnt != 3'd0 ? out_mem[out_rd] : '0;
        else if (is_coef) rdata = coef_rd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_o <= 1'b0;
            dat_o <= '0;
            en <= 1'b0;
            ie <= 1'b0;
            ovf <= 1'b0;
            unf <= 1'b0;
            state <= IDLE;
            k <= '0;
            acc <= '0;
            in_rd <= '0;
            in_wr <= '0;
            in_cnt <= '0;
            out_rd <= '0;
            out_wr <= '0;
            out_cnt <= '0;
            for (int i = 0; i < N; i++) begin
                coef[i] <= '0;
                x[i] <= '0;
            end
        end else begin
            ack_o <= go;
            dat_o <= rd ? rdata : '0;
            if (wr && adr_i == 4'd0) {ie, en} <= {dat_i[2], dat_i[0]};
            for (int i = 0; i < N; i++)
                if (wr && is_coef && cidx == 4'(i)) coef[i] <= dat_i;
            if (clr) begin
                ovf <= 1'b0;
                unf <= 1'b0;
                state <= IDLE;
                k <= '0;
                acc <= '0;
                in_rd <= '0;
                in_wr <= '0;
                in_cnt <= '0;
                out_rd <= '0;
                out_wr <= '0;
                out_cnt <= '0;
                for (int i = 0; i < N; i++) x[i] <= '0;
            end else begin
                if (in_acc) begin
                    in_mem[in_wr] <= dat_i;
                    in_wr <= in_wr + 2'd1;
                end
                if (in_pop) in_rd <= in_rd + 2'd1;
                in_cnt <= in_cnt + 3'(in_acc) - 3'(in_pop);
                if (out_push) begin
                    out_mem[out_wr] <= result;
                    out_wr <= out_wr + 2'd1;
                end
                if (out_pop) out_rd <= out_rd + 2'd1;
                out_cnt <= out_cnt + 3'(out_push) - 3'(out_pop);
                ovf <= (ovf & ~(st_wr & dat_i[5])) | (in_push & ~in_acc);
                unf <= (unf & ~(st_wr & dat_i[6])) | (rd & (adr_i == 4'd3) & (out_cnt == 3'd0));
                if (state == IDLE) begin
                    if (en && in_cnt != 3'd0 && out_cnt != 3'd4) state <= SHIFT;
                end else if (state == SHIFT) begin
                    x[0] <= in_mem[in_rd];
                    for (int i = 1; i < N; i++) x[i] <= x[i-1];
                    acc <= '0;
                    k <= '0;
                    state <= MAC;
                end else if (state == MAC) begin
                    acc <= acc + {{4{prod[2*W-1]}}, prod};
                    k <= k + 4'd1;
                    if (k == 4'(N - 1)) state <= ROUND;
                end else begin
                    state <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_fir_wb_responder.sv
// tb_fir_wb_responder: randomized register-level bench against a floating-free integer FIR reference model.
module tb_fir_wb_responder;
    logic clk = 0, rst = 1, we = 0, stb = 0, cyc = 0;
    logic [3:0] adr = 0;
    logic [15:0] wdat = 0, rdat;
    logic ack, irq;
    int errors = 0, checks = 0;
    logic prev_ack = 0;
    logic signed [15:0] mc [4] = '{default: 0};
    logic signed [15:0] mx [4] = '{default: 0};
    logic [15:0] exp_q [$];

    fir_wb_responder #(.N(4), .DATA_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .adr_i(adr), .dat_i(wdat), .dat_o(rdat),
        .we_i(we), .stb_i(stb), .cyc_i(cyc), .ack_o(ack), .irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ack) chk("ack_pulse", {31'b0, prev_ack}, 0);
        prev_ack = ack;
    end

    task automatic xfer(input logic [3:0] a, input logic w, input logic [15:0] d,
                        output logic [15:0] q, output int n);
        n = 0;
        @(posedge clk); #1;
        adr = a; we = w; wdat = d; stb = 1; cyc = 1;
        while (n < 64) begin
            @(posedge clk); #1;
            n++;
            if (ack) break;
        end
        chk("ack_seen", {31'b0, ack}, 1);
        q = rdat;
        stb = 0; cyc = 0; we = 0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        logic [15:0] q;
        int n;
        xfer(a, 1, d, q, n);
    endtask

    task automatic rd(input logic [3:0] a, output logic [15:0] q);
        int n;
        xfer(a, 0, 16'h0, q, n);
    endtask

    function automatic logic [15:0] model(input logic [15:0] s);
        longint acc = 0;
        for (int i = 3; i > 0; i--) mx[i] = mx[i-1];
        mx[0] = s;
        for (int i = 0; i < 4; i++) acc += longint'(mx[i]) * longint'(mc[i]);
        acc = acc >>> 15;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        return 16'(acc);
    endfunction

    task automatic feed(input logic [15:0] s);
        wr(4'd2, s);
        exp_q.push_back(model(s));
    endtask

    task automatic drain(output logic [15:0] last);
        logic [15:0] q;
        last = 0;
        repeat (40) @(posedge clk);
        while (exp_q.size() > 0) begin
            rd(4'd3, q);
            last = exp_q.pop_front();
            chk("dout", q, last);
        end
    endtask

    task automatic set_coef(input int i, input logic [15:0] c);
        wr(4'(4 + i), c);
        mc[i] = c;
    endtask

    task automatic impulse();
        logic [15:0] q;
        int n;
        logic [15:0] want [4] = '{16'h3FFF, 16'h1FFF, 16'h0FFF, 16'h07FF};
        set_coef(0, 16'h4000);
        set_coef(1, 16'h2000);
        set_coef(2, 16'h1000);
        set_coef(3, 16'h0800);
        wr(4'd0, 16'h5);
        feed(16'h7FFF);
        n = 0;
        while (!irq && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, 7);
        for (int i = 0; i < 3; i++) feed(16'h0);
        repeat (40) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            rd(4'd3, q);
            chk("impulse", q, want[i]);
            chk("impulse_model", q, exp_q.pop_front());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] q, last;
        int n;
        repeat (3) @(posedge clk); #1;
        chk("rst_ack", {31'b0, ack}, 0);
        chk("rst_dat", rdat, 0);
        chk("rst_irq", {31'b0, irq}, 0);
        rst = 0;
        rd(4'd1, q);
        chk("rst_status", q, 16'h000A);

        impulse();

        feed(16'h1234);
        exp_q.delete();
        repeat (3) @(posedge clk); #1;
        rst = 1; #1;
        chk("midmac_ack", {31'b0, ack}, 0);
        chk("midmac_dat", rdat, 0);
        chk("midmac_irq", {31'b0, irq}, 0);
        @(posedge clk); #1;
        rst = 0;
        mc = '{default: 0};
        mx = '{default: 0};
        rd(4'd1, q);
        chk("midmac_status", q, 16'h000A);
        rd(4'd4, q);
        chk("midmac_coef0", q, 0);

        set_coef(0, 16'h4000);
        wr(4'd0, 16'h1);
        feed(16'h2000);
        drain(last);
        chk("gain", last, 16'h1000);
        for (int i = 0; i < 4; i++) set_coef(i, 16'h7FFF);
        for (int i = 0; i < 4; i++) feed(16'h7FFF);
        drain(last);
        chk("sat_pos", last, 16'h7FFF);
        for (int i = 0; i < 4; i++) feed(16'h8000);
        drain(last);
        chk("sat_neg", last, 16'h8000);

        wr(4'd0, 16'h0);
        for (int i = 0; i < 4; i++) feed(16'($urandom));
        wr(4'd2, 16'h5555);
        rd(4'd1, q);
        chk("in_full", {31'b0, q[2]}, 1);
        chk("ovf_set", {31'b0, q[5]}, 1);
        wr(4'd0, 16'h1);
        repeat (50) @(posedge clk);
        rd(4'd1, q);
        chk("out_count4", {29'b0, q[9:7]}, 4);
        chk("out_full", {31'b0, q[4]}, 1);
        drain(last);
        rd(4'd3, q);
        chk("underflow_data", q, 0);
        rd(4'd1, q);
        chk("unf_set", {31'b0, q[6]}, 1);
        wr(4'd1, 16'h0060);
        rd(4'd1, q);
        chk("flags_w1c", {30'b0, q[6:5]}, 0);

        wr(4'd0, 16'h0);
        @(posedge clk); #1;
        adr = 4'd2; we = 1; wdat = 16'h4321; stb = 1; cyc = 1;
        #3;
        stb = 0; cyc = 0; we = 0;
        repeat (2) @(posedge clk); #1;
        chk("drop_ack", {31'b0, ack}, 0);
        rd(4'd1, q);
        chk("drop_in_empty", {31'b0, q[1]}, 1);
        rd(4'd2, q);
        chk("data_in_read", q, 0);
        rd(4'd15, q);
        chk("unmapped_read", q, 0);

        wr(4'd0, 16'h1);
        feed(16'h0100);
        repeat (2) @(posedge clk);
        xfer(4'd4, 1, 16'h0200, q, n);
        chk("coef_stall_cycles", n, 5);
        mc[0] = 16'h0200;
        rd(4'd1, q);
        chk("stall_busy", {31'b0, q[0]}, 0);
        rd(4'd4, q);
        chk("coef_after_stall", q, 16'h0200);
        drain(last);

        wr(4'd0, 16'h5);
        feed(16'h1234);
        repeat (20) @(posedge clk); #1;
        chk("irq_on", {31'b0, irq}, 1);
        wr(4'd0, 16'h7);
        chk("irq_clr", {31'b0, irq}, 0);
        exp_q.delete();
        mx = '{default: 0};
        rd(4'd1, q);
        chk("clr_count", {29'b0, q[9:7]}, 0);
        rd(4'd0, q);
        chk("ctrl_read", q, 16'h5);
        impulse();

        wr(4'd0, 16'h1);
        for (int r = 0; r < 12; r++) begin
            if (r % 3 == 0)
                for (int i = 0; i < 4; i++) set_coef(i, 16'($urandom));
            for (int b = 0; b < int'($urandom_range(1, 4)); b++) feed(16'($urandom));
            drain(last);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
